mpu_sample_sequencer: RTL
=========================

# mpu_sample_sequencer

- Paces accelerometer acquisition at a fixed sample rate.
- On each rate tick, it issues a 6-byte burst-read request to the I2C byte-stream master.
- It assembles the returned big-endian bytes into signed ax/ay/az and presents each complete sample to fall_detect as a one-cycle data_valid pulse.
- It sits between the I2C master and fall_detect, counts dropped ticks (overruns) and aborted transactions (bus error / timeout), and never publishes a partial sample.

## Interface
- CLK_FREQ_HZ, 50_000_000: clock frequency.
- SAMPLE_RATE_HZ, 50: sample tick rate. PERIOD = CLK_FREQ_HZ/SAMPLE_RATE_HZ cycles; must be ≥ 2.
- TIMEOUT_CYCLES, 100_000: maximum cycles allowed in REQ or RECV before abort; must be ≥ 1.
- START_REG, 8'h3B: first register address of the burst (ACCEL_XOUT_H).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  1 = tick counter runs and new transactions may start.
- rd_req  out  1  burst-read request, held until acknowledged.
- rd_addr  out  8  start register; equals START_REG whenever rd_req = 1.
- rd_len  out  3  byte count, constant 6.
- rd_ack  in  1  master accepted the request.
- rx_valid  in  1  rx_data holds one returned byte this cycle.
- rx_data  in  8  returned byte.
- bus_error  in  1  master reports NACK/arbitration loss for the current transaction.
- data_valid  out  1  one-cycle pulse; ax/ay/az hold a new sample.
- ax, ay, az  out  16 signed  last published sample; held between pulses.
- sample_count  out  16  published samples; wraps modulo 2^16.
- err_count  out  8  aborted transactions; saturates at 255.
- overrun_count  out  8  ticks dropped while busy; saturates at 255.

## Operation
- Tick counter:
  - 0..PERIOD-1 while enable = 1; the tick pulse occurs when the count equals PERIOD-1, then the count returns to 0.
  - enable = 0 forces the count to 0 and produces no ticks.
- FSM states are IDLE, REQ, RECV, PUBLISH; reset state is IDLE.
- IDLE: a tick moves to REQ.
- REQ:
  - rd_req = 1.
  - rd_ack = 1 moves to RECV with byte index 0 and the timer cleared.
- RECV:
  - Each rx_valid stores rx_data into shadow byte [index], and the index increments.
  - Storing byte 5 moves to PUBLISH.
- PUBLISH (one cycle):
  - ax = {b0,b1}, ay = {b2,b3}, az = {b4,b5}.
  - data_valid = 1, sample_count += 1.
  - Then IDLE.
- Abort: from REQ or RECV, bus_error = 1 or the timer reaching TIMEOUT_CYCLES-1 causes:
  - return to IDLE;
  - err_count += 1 (saturating);
  - no publish;
  - shadow bytes discarded; ax/ay/az unchanged.
- Timer: cleared on entry to REQ and on entry to RECV; increments each cycle spent in REQ/RECV.
- Priority in REQ/RECV within one cycle: bus_error > timeout > rd_ack / rx_valid.
- Tick arriving in REQ, RECV or PUBLISH: tick dropped, overrun_count += 1 (saturating). Ticks are never queued.
- enable falling mid-transaction: the current transaction completes or aborts normally; no new transaction starts.
- Ignored inputs:
  - rx_valid in IDLE, REQ or PUBLISH.
  - rd_ack outside REQ.
  - bus_error outside REQ/RECV.

## Timing
- Reset values: rd_req = 0, rd_addr = START_REG, rd_len = 6, data_valid = 0, ax = ay = az = 0, all counters 0, tick counter 0, state IDLE.
- All outputs are registered; there is no combinational input-to-output path.
- Tick on cycle T (in IDLE): rd_req = 1 from T+1.
- rd_ack high on cycle A: rd_req = 0 from A+1.
- Byte 5 accepted on cycle B: data_valid = 1 and new ax/ay/az on B+1 only. sample_count reflects the increment from B+2.
- Minimum cycles from rd_ack to data_valid = 7 (six back-to-back bytes).
- rst asserted at any time: immediate return to reset values. An in-flight transaction is abandoned without err_count increment.

## Test plan
Test parameters: CLK_FREQ_HZ = 1000, SAMPLE_RATE_HZ = 100 (PERIOD = 10), TIMEOUT_CYCLES = 20.
- Normal read:
  - Stimulus: enable = 1; ack 2 cycles after rd_req; bytes 07 D0 05 DC 03 E8 back-to-back.
  - Response: ax = 2000, ay = 1500, az = 1000; one data_valid pulse; sample_count = 1; rd_addr = 8'h3B during rd_req.
- Negative values:
  - Stimulus: bytes 9E 58 FF FF 80 00.
  - Response: ax = -25000, ay = -1, az = -32768.
- Overrun:
  - Stimulus: stall bytes so the transaction spans two ticks (data arriving 12 cycles after ack).
  - Response: overrun_count = 1, single data_valid, no second rd_req until the next tick after IDLE.
- Timeout:
  - Stimulus: ack, then only 3 bytes.
  - Response: abort 20 cycles after entering RECV; err_count = 1; no data_valid; ax/ay/az retain the previous sample.
- Bus error priority:
  - Stimulus: bus_error and rx_valid (byte 5) in the same cycle.
  - Response: no publish, err_count increments.
- Reset and enable:
  - Stimulus: rst pulse mid-RECV.
  - Response: all outputs return to reset values, err_count = 0.
  - Stimulus: enable = 0 for 50 cycles.
  - Response: no rd_req.
  - Stimulus: re-enable.
  - Response: first rd_req exactly 10 cycles after enable rises.

Source files
------------

// File: rtl/mpu_sample_sequencer.sv
// mpu_sample_sequencer
// Paces accelerometer acquisition. Every sample tick it asks the I2C
// byte-stream master for a 6-byte burst starting at START_REG, assembles the
// big-endian bytes into signed ax/ay/az and publishes each complete sample
// with a one-cycle data_valid pulse. Ticks that arrive while a transaction is
// still in flight are dropped and counted. Transactions killed by bus_error
// or by the watchdog timer are counted and never published.
//
// Ports
//   clk, rst        system clock (rising edge), async active-high reset
//   enable          lets the tick counter run and new transactions start
//   rd_req          burst-read request, held until rd_ack
//   rd_addr         first register of the burst (constant START_REG)
//   rd_len          burst length in bytes (constant 6)
//   rd_ack          master accepted the request
//   rx_valid        rx_data carries one returned byte
//   rx_data         returned byte
//   bus_error       master reports NACK / arbitration loss
//   data_valid      one-cycle pulse, ax/ay/az hold a new sample
//   ax, ay, az      last published sample (signed, held between pulses)
//   sample_count    published samples, wraps
//   err_count       aborted transactions, saturating
//   overrun_count   dropped ticks, saturating
module mpu_sample_sequencer #(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned SAMPLE_RATE_HZ = 50,
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter logic [7:0]  START_REG      = 8'h3B
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               rd_req,
    output logic [7:0]         rd_addr,
    output logic [2:0]         rd_len,
    input  logic               rd_ack,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               bus_error,
    output logic               data_valid,
    output logic signed [15:0] ax,
    output logic signed [15:0] ay,
    output logic signed [15:0] az,
    output logic [15:0]        sample_count,
    output logic [7:0]         err_count,
    output logic [7:0]         overrun_count
);

    localparam int unsigned PERIOD = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
    localparam int TICK_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV, PUBLISH} state_t;

    state_t            state, state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [TMR_W-1:0]  timer;
    logic [2:0]        byte_idx;
    logic [39:0]       shadow;
    logic              tick, timed_out, abort, store_byte, last_byte, overrun;

    assign rd_addr = START_REG;
    assign rd_len  = 3'd6;

    assign tick      = enable && (tick_cnt == TICK_LAST);
    assign timed_out = (timer == TMR_LAST);
    assign last_byte = (byte_idx == 3'd5);

    // Free-running sample-rate divider; held at zero while disabled so the
    // first tick after enable rises lands a full period later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (!enable || tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Next-state decode. bus_error beats the timeout, which beats
    // rd_ack / rx_valid, so an abort always wins a same-cycle race.
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        store_byte = 1'b0;
        overrun    = tick && (state != IDLE);
        case (state)
            IDLE: begin
                if (tick) state_next = REQ;
            end
            REQ: begin
                if (bus_error || timed_out) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (rd_ack) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (bus_error || timed_out) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (rx_valid) begin
                    store_byte = 1'b1;
                    if (last_byte) state_next = PUBLISH;
                end
            end
            PUBLISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus the registered request / valid strobes, decoded
    // from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_req     <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_next;
            rd_req     <= (state_next == REQ);
            data_valid <= (state_next == PUBLISH);
        end
    end

    // Datapath: watchdog timer, byte collection, sample publish, counters.
    // The first five bytes shift through a 40-bit shadow; the sixth byte is
    // taken straight from rx_data so the sample appears the cycle after it.
    // Any state change clears the timer, which covers entry to REQ and RECV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer         <= '0;
            byte_idx      <= '0;
            shadow        <= '0;
            ax            <= '0;
            ay            <= '0;
            az            <= '0;
            sample_count  <= '0;
            err_count     <= '0;
            overrun_count <= '0;
        end else begin
            if (state_next != state) begin
                timer <= '0;
            end else if (state == REQ || state == RECV) begin
                timer <= timer + 1'b1;
            end

            if (state == REQ && state_next == RECV) begin
                byte_idx <= '0;
            end else if (store_byte) begin
                byte_idx <= byte_idx + 1'b1;
            end

            if (store_byte) begin
                shadow <= {shadow[31:0], rx_data};
            end

            if (store_byte && last_byte) begin
                ax <= {shadow[39:32], shadow[31:24]};
                ay <= {shadow[23:16], shadow[15:8]};
                az <= {shadow[7:0], rx_data};
            end

            if (state == PUBLISH) begin
                sample_count <= sample_count + 1'b1;
            end

            if (abort && err_count != 8'hFF) begin
                err_count <= err_count + 1'b1;
            end

            if (overrun && overrun_count != 8'hFF) begin
                overrun_count <= overrun_count + 1'b1;
            end
        end
    end

endmodule
